if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the ARM pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues one instruction-memory request at a time over a req/ack handshake, so memory latency may vary.
- Presents the fetched instruction and its PC+4 to the IF/ID register.
- Handles downstream freeze by buffering a returned instruction, and handles branch redirects, including redirects that arrive while a memory request is still outstanding.

---
 rtl/if_fetch_unit.sv | 128 ++++++++++++
 tb/tb_if_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time over
// req/ack, buffers a word under freeze and squashes wrong-path returns on redirect.
module if_fetch_unit #(
  parameter int                     ADDRESS_LEN = 32,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDRESS_LEN-1:0] branch_addr,
  output logic                   imem_req,
  output logic [ADDRESS_LEN-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [ADDRESS_LEN-1:0] imem_rdata,
  output logic [ADDRESS_LEN-1:0] pc_out,
  output logic [ADDRESS_LEN-1:0] instruction_out,
  output logic                   instr_valid
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t                 r_state;
  logic [ADDRESS_LEN-1:0] r_pc;
  logic [ADDRESS_LEN-1:0] r_hold_instr;
  logic [ADDRESS_LEN-1:0] r_hold_pc4;
  logic [ADDRESS_LEN-1:0] r_redirect_pc;

  logic [ADDRESS_LEN-1:0] w_pc4;
  logic                   w_valid;
  logic [ADDRESS_LEN-1:0] w_instr;
  logic [ADDRESS_LEN-1:0] w_pc_out;

  assign w_pc4 = r_pc + ADDRESS_LEN'(4);

  // Outputs are decoded straight from state so a same-cycle ack reaches IF/ID
  // without an added cycle; rst gates them so they read 0 asynchronously.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    imem_req  = 1'b0;
    imem_addr = '0;
    w_valid   = 1'b0;
    w_instr   = '0;
    w_pc_out  = '0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          imem_req  = 1'b1;
          imem_addr = r_pc;
          w_valid   = imem_ack & ~branch_taken;
          w_instr   = imem_rdata;
          w_pc_out  = w_pc4;
        end
        S_HOLD: begin
          w_valid  = ~branch_taken;
          w_instr  = r_hold_instr;
          w_pc_out = r_hold_pc4;
        end
        S_DISCARD: begin
          imem_req  = 1'b1;
          imem_addr = r_pc;
        end
        default: ;
      endcase
    end
  end

  assign instr_valid     = w_valid;
  assign instruction_out = w_valid ? w_instr  : '0;
  assign pc_out          = w_valid ? w_pc_out : '0;

  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these are plain datapath registers, not a memory array, so they
      // are cheap to clear and a stray post-reset read yields 0, not X.
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_hold_instr  <= '0;
      r_hold_pc4    <= '0;
      r_redirect_pc <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            if (branch_taken) begin
              r_pc <= branch_addr;
            end else begin
              r_pc <= w_pc4;
              if (freeze) begin
                r_hold_instr <= imem_rdata;
                r_hold_pc4   <= w_pc4;
                r_state      <= S_HOLD;
              end
            end
          end else if (branch_taken) begin
            r_redirect_pc <= branch_addr;
            r_state       <= S_DISCARD;
          end
        end
        S_HOLD: begin
          if (branch_taken) begin
            r_pc    <= branch_addr;
            r_state <= S_FETCH;
          end else if (!freeze) begin
            r_state <= S_FETCH;
          end
        end
        S_DISCARD: begin
          // The request in flight must finish at its original address; only the
          // newest redirect target is remembered until the ack drains it.
          if (branch_taken) r_redirect_pc <= branch_addr;
          if (imem_ack) begin
            r_pc    <= branch_taken ? branch_addr : r_redirect_pc;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios then randomized
// ack/freeze/branch traffic against a transaction-level fetch model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        instr_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the address being fetched, an optional parked word, and an
  // optional pending redirect that waits for the in-flight word to drain.
  logic [31:0] m_pc;
  bit          m_parked;
  logic [31:0] m_park_word;
  logic [31:0] m_park_pc4;
  bit          m_squash;
  logic [31:0] m_target;

  if_fetch_unit #(.ADDRESS_LEN(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .pc_out         (pc_out),
    .instruction_out(instruction_out),
    .instr_valid    (instr_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A01005;
    return {a[15:0] ^ 16'hC3C3, a[17:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc        = 32'h0;
    m_parked    = 1'b0;
    m_park_word = 32'h0;
    m_park_pc4  = 32'h0;
    m_squash    = 1'b0;
    m_target    = 32'h0;
  endtask

  // Called at posedge+1: drive one cycle, check outputs, advance model, move on.
  task automatic step(input logic a, input logic f, input logic b, input logic [31:0] ba);
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    imem_ack     = a;
    freeze       = f;
    branch_taken = b;
    branch_addr  = ba;
    imem_rdata   = a ? mem_word(imem_addr) : 32'hDEADBEEF;
    #2;
    e_req   = !m_parked;
    e_valid = m_parked ? !b : (!m_squash && a && !b);
    e_instr = m_parked ? m_park_word : mem_word(m_pc);
    e_pc4   = m_parked ? m_park_pc4  : m_pc + 32'd4;
    check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) check("imem_addr", imem_addr, m_pc);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, e_valid});
    check("instruction_out", instruction_out, e_valid ? e_instr : 32'h0);
    check("pc_out", pc_out, e_valid ? e_pc4 : 32'h0);

    if (m_parked) begin
      if (b) begin
        m_pc     = ba;
        m_parked = 1'b0;
      end else if (!f) begin
        m_parked = 1'b0;
      end
    end else if (m_squash) begin
      if (b) m_target = ba;
      if (a) begin
        m_pc     = m_target;
        m_squash = 1'b0;
      end
    end else if (b) begin
      if (a) m_pc = ba;
      else begin
        m_squash = 1'b1;
        m_target = ba;
      end
    end else if (a) begin
      if (f) begin
        m_parked    = 1'b1;
        m_park_word = mem_word(m_pc);
        m_park_pc4  = m_pc + 32'd4;
      end
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    imem_ack = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
    branch_addr = 32'h0; imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    apply_reset();

    // Zero-latency memory: one instruction per cycle.
    for (int i = 0; i < 4; i++) begin
      check("tp1_addr", imem_addr, 32'(4 * i));
      step(1'b1, 1'b0, 1'b0, 32'h0);
    end

    // Two-cycle memory latency at address 0.
    apply_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("tp2_word", instruction_out, 32'h0);
    imem_ack = 1'b1; imem_rdata = mem_word(imem_addr); #1;
    check("tp2_instr", instruction_out, 32'hE3A01005);
    check("tp2_pc4", pc_out, 32'h4);
    #1;
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Freeze on the word at address 8 for three cycles.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("tp3_hold_pc4", pc_out, 32'd12);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("tp3_next_addr", imem_addr, 32'd12);

    // Redirect while a request at 0x20 is outstanding.
    step(1'b1, 1'b0, 1'b1, 32'h20);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h100);
    check("tp4_addr_held", imem_addr, 32'h20);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("tp4_new_addr", imem_addr, 32'h100);

    // Second redirect coincides with the draining ack: newest target wins.
    step(1'b0, 1'b0, 1'b1, 32'h150);
    step(1'b1, 1'b0, 1'b1, 32'h200);
    check("tp5_new_addr", imem_addr, 32'h200);

    // PC+4 wraps at the top of the address space.
    step(1'b1, 1'b0, 1'b1, 32'hFFFFFFFC);
    imem_ack = 1'b1; imem_rdata = mem_word(imem_addr); #1;
    check("wrap_pc4", pc_out, 32'h0);
    #1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // Async reset during an outstanding request at 0x40.
    step(1'b1, 1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h12345678;
    #1;
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instruction_out, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("rst_addr", imem_addr, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic        a;
      logic        f;
      logic        b;
      logic [31:0] ba;
      a  = !m_parked && ($urandom_range(0, 2) == 0);
      f  = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 7) == 0);
      ba = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
      step(a, f, b, ba);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
